// File: rtl/phys_reg_reclaim_queue.sv
// Reclaim queue between retire and the physical register free list.
// Build option: define RECLAIM_BYPASS_EN to forward a tag retired into an
// empty, unstalled queue straight to the free list in the same cycle.
//
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   retire_valid               committing instr frees its old dest mapping
//   retire_arch_reg_tag        arch dest of the committing instr
//   retire_phys_reg_tag        previous (now dead) physical mapping
//   retire_ready               registered; a retire is accepted this cycle
//   drain_stall                holds the head, no pop this cycle
//   enqueue_valid              free list enqueue strobe (always accepted)
//   enqueue_phys_reg_tag       tag presented to the free list
//   count                      registered occupancy
//   overflow_error             sticky; retire seen while not ready

package phys_reg_reclaim_pkg;
    parameter int ARCH_TAG_W = 5;
    parameter int PHYS_TAG_W = 7;
    typedef logic [ARCH_TAG_W-1:0] arch_reg_tag_t;
    typedef logic [PHYS_TAG_W-1:0] phys_reg_tag_t;
endpackage

module phys_reg_reclaim_queue
    import phys_reg_reclaim_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int LOG_DEPTH = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 retire_valid,
    input  arch_reg_tag_t        retire_arch_reg_tag,
    input  phys_reg_tag_t        retire_phys_reg_tag,
    output logic                 retire_ready,
    input  logic                 drain_stall,
    output logic                 enqueue_valid,
    output phys_reg_tag_t        enqueue_phys_reg_tag,
    output logic [LOG_DEPTH:0]   count,
    output logic                 overflow_error
);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [LOG_DEPTH:0] head_q, head_d;
    logic [LOG_DEPTH:0] tail_q, tail_d;
    logic [LOG_DEPTH:0] count_q, count_d;
    logic               ready_q, ready_d;
    logic               ovf_q, ovf_d;
    phys_reg_tag_t      mem_q [DEPTH];

    logic empty;
    logic next_full;
    logic accept;
    logic bypass;
    logic push;
    logic pop;

    assign empty  = (head_q == tail_q);
    // Retires of arch reg 0 never held a real mapping; drop them.
    assign accept = retire_valid & ready_q &
                    (retire_arch_reg_tag != '0);

`ifdef RECLAIM_BYPASS_EN
    assign bypass = accept & empty & ~drain_stall;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept & ~bypass;
    // The free list never backpressures, so presenting a tag is a pop.
    assign pop  = ~empty & ~drain_stall;

    assign tail_d  = tail_q + (LOG_DEPTH+1)'(push);
    assign head_d  = head_q + (LOG_DEPTH+1)'(pop);
    assign count_d = tail_d - head_d;

    assign next_full =
        (tail_d[LOG_DEPTH-1:0] == head_d[LOG_DEPTH-1:0]) &
        (tail_d[LOG_DEPTH] != head_d[LOG_DEPTH]);

    // Ready is the registered complement of fullness, so a pop on a
    // full queue only reopens the input on the following cycle.
    assign ready_d = ~next_full;
    assign ovf_d   = ovf_q | (retire_valid & ~ready_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[tail_q[LOG_DEPTH-1:0]] <= retire_phys_reg_tag;
        end
    end

    assign enqueue_valid        = ~RST & (pop | bypass);
    assign enqueue_phys_reg_tag = bypass ? retire_phys_reg_tag
                                         : mem_q[head_q[LOG_DEPTH-1:0]];

    assign retire_ready   = ready_q;
    assign count          = count_q;
    assign overflow_error = ovf_q;

endmodule

// File: tb/tb_phys_reg_reclaim_queue.sv
// Scoreboard bench for phys_reg_reclaim_queue: directed retires push
// expected tags; a negedge monitor pops and compares every enqueue.

module tb_phys_reg_reclaim_queue;
    import phys_reg_reclaim_pkg::*;

    localparam int DEPTH = 8;
    localparam int LD    = 3;

`ifdef RECLAIM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          retire_valid;
    arch_reg_tag_t retire_arch_reg_tag;
    phys_reg_tag_t retire_phys_reg_tag;
    logic          retire_ready;
    logic          drain_stall;
    logic          enqueue_valid;
    phys_reg_tag_t enqueue_phys_reg_tag;
    logic [LD:0]   count;
    logic          overflow_error;

    int errors = 0;
    int checks = 0;
    phys_reg_tag_t exp_q[$];

    phys_reg_reclaim_queue #(.DEPTH(DEPTH)) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .retire_valid         (retire_valid),
        .retire_arch_reg_tag  (retire_arch_reg_tag),
        .retire_phys_reg_tag  (retire_phys_reg_tag),
        .retire_ready         (retire_ready),
        .drain_stall          (drain_stall),
        .enqueue_valid        (enqueue_valid),
        .enqueue_phys_reg_tag (enqueue_phys_reg_tag),
        .count                (count),
        .overflow_error       (overflow_error)
    );

    always #5 CLK = ~CLK;

    // Monitor: every presented tag must match the scoreboard head.
    always @(negedge CLK) begin
        if (enqueue_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_enqueue: got tag %0d, none expected",
                         enqueue_phys_reg_tag);
            end else begin
                phys_reg_tag_t e;
                e = exp_q.pop_front();
                if (enqueue_phys_reg_tag !== e) begin
                    errors++;
                    $display("FAIL enqueue_order: got tag %0d, expected %0d",
                             enqueue_phys_reg_tag, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge to drive inputs.
    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        retire_valid        = 1'b0;
        retire_arch_reg_tag = '0;
        retire_phys_reg_tag = '0;
    endtask

    task automatic retire(input int a, input int p, input bit expect_push);
        retire_valid        = 1'b1;
        retire_arch_reg_tag = arch_reg_tag_t'(a);
        retire_phys_reg_tag = phys_reg_tag_t'(p);
        if (expect_push) exp_q.push_back(phys_reg_tag_t'(p));
    endtask

    initial begin
        RST         = 1'b1;
        drain_stall = 1'b0;
        idle();

        // Reset held
        next_cyc();
        next_cyc();
        @(negedge CLK);
        chk("ev_in_reset", int'(enqueue_valid), 0);
        next_cyc();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_count", int'(count), 0);
        chk("rst_ready", int'(retire_ready), 1);
        chk("rst_ovf", int'(overflow_error), 0);
        chk("rst_ev", int'(enqueue_valid), 0);

        // Single retire arch 5 / phys 40
        next_cyc();
        retire(5, 40, 1'b1);
        @(negedge CLK);
        chk("lat_cycle1_ev", int'(enqueue_valid), int'(BYP));
        next_cyc();
        idle();
        @(negedge CLK);
        chk("lat_cycle2_ev", int'(enqueue_valid), int'(!BYP));
        next_cyc();
        @(negedge CLK);
        chk("single_count", int'(count), 0);
        chk("single_drained", exp_q.size(), 0);

        // Arch 0 retire is dropped
        next_cyc();
        retire(0, 12, 1'b0);
        @(negedge CLK);
        chk("arch0_ev_same", int'(enqueue_valid), 0);
        next_cyc();
        idle();
        @(negedge CLK);
        chk("arch0_ev_next", int'(enqueue_valid), 0);
        chk("arch0_count", int'(count), 0);

        // Fill under stall with 33..40, then overflow
        drain_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            next_cyc();
            retire(1 + i, 33 + i, 1'b1);
            if (i == 7) begin
                @(negedge CLK);
                chk("ready_before_full", int'(retire_ready), 1);
                chk("count_7", int'(count), 7);
            end
        end
        next_cyc();
        retire(3, 99, 1'b0);
        @(negedge CLK);
        chk("full_count", int'(count), 8);
        chk("full_ready", int'(retire_ready), 0);
        chk("stall_ev", int'(enqueue_valid), 0);
        next_cyc();
        idle();
        @(negedge CLK);
        chk("ovf_set", int'(overflow_error), 1);
        chk("ovf_count", int'(count), 8);

        // Release stall: drain 33..40 in order
        next_cyc();
        drain_stall = 1'b0;
        @(negedge CLK);
        chk("first_pop_ready", int'(retire_ready), 0);
        chk("first_pop_ev", int'(enqueue_valid), 1);
        next_cyc();
        @(negedge CLK);
        chk("ready_after_pop", int'(retire_ready), 1);
        for (int i = 0; i < 8; i++) next_cyc();
        @(negedge CLK);
        chk("drain_count", int'(count), 0);
        chk("drain_done", exp_q.size(), 0);
        chk("ovf_sticky", int'(overflow_error), 1);

        // Steady push+pop, tags 48..67
        for (int i = 0; i < 20; i++) begin
            next_cyc();
            retire(7, 48 + i, 1'b1);
            if (i > 0) begin
                @(negedge CLK);
                chk("steady_count", int'(count), BYP ? 0 : 1);
            end
        end
        next_cyc();
        idle();
        next_cyc();
        next_cyc();
        @(negedge CLK);
        chk("steady_drained", exp_q.size(), 0);
        chk("steady_count_end", int'(count), 0);

        // Reset with five entries in flight, retire asserted alongside
        drain_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            retire(1, 1 + i, 1'b1);
        end
        next_cyc();
        idle();
        @(negedge CLK);
        chk("pre_rst_count", int'(count), 5);
        next_cyc();
        RST = 1'b1;
        retire(9, 77, 1'b0);
        drain_stall = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        chk("rst_mid_ev", int'(enqueue_valid), 0);
        next_cyc();
        RST = 1'b0;
        idle();
        @(negedge CLK);
        chk("rst2_count", int'(count), 0);
        chk("rst2_ev", int'(enqueue_valid), 0);
        chk("rst2_ovf", int'(overflow_error), 0);
        chk("rst2_ready", int'(retire_ready), 1);
        for (int i = 0; i < 4; i++) next_cyc();
        @(negedge CLK);
        chk("rst2_quiet", int'(enqueue_valid), 0);
        chk("final_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phys_reg_reclaim_queue.md
PHYS_REG_RECLAIM_QUEUE -- requirements
Module: phys_reg_reclaim_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, reclaim FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter LOG_DEPTH, default $clog2(DEPTH), FIFO index width.
REQ-003 SHALL have CLK  in  1  rising-edge clock; one clock domain.
REQ-004 SHALL have RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have retire_valid  in  1  committing instr releases its old dest mapping.
REQ-006 SHALL have retire_arch_reg_tag  in  arch_reg_tag_t  arch dest of committing instr.
REQ-007 SHALL have retire_phys_reg_tag  in  phys_reg_tag_t  previous (now dead) phys mapping.
REQ-008 SHALL have retire_ready  out  1  registered; queue accepts a retire this cycle.
REQ-009 SHALL have drain_stall  in  1  suppresses output this cycle, e.g. during free list restore.
REQ-010 SHALL have enqueue_valid  out  1  drives free list enqueue_valid.
REQ-011 SHALL have enqueue_phys_reg_tag  out  phys_reg_tag_t  drives free list enqueue_phys_reg_tag.
REQ-012 SHALL have count  out  LOG_DEPTH+1  registered occupancy.
REQ-013 SHALL have overflow_error  out  1  sticky; set on retire_valid while ~retire_ready.

Function
REQ-014 SHALL hold tags in a circular FIFO with head/tail pointers of LOG_DEPTH index bits plus wrap msb. Empty: index and msb equal. Full: index equal, msb differs.
REQ-015 SHALL push retire_phys_reg_tag at tail when retire_valid & retire_ready & retire_arch_reg_tag != 0. Arch reg 0 retires are dropped silently and count is unchanged.
REQ-016 SHALL set enqueue_valid = ~empty & ~drain_stall and enqueue_phys_reg_tag = entry at head. A pop occurs whenever enqueue_valid=1, because the free list always accepts.
REQ-017 SHALL hold enqueue_phys_reg_tag at the head value while drain_stall=1. No pop occurs.
REQ-018 SHALL support push and pop in the same cycle. count is unchanged; both pointers advance.
REQ-019 SHALL register retire_ready = ~next_full, so at most DEPTH entries are ever held. Ready stays low while full even if a pop occurs that cycle, and rises the next cycle.
REQ-020 SHALL drop the tag on retire_valid & ~retire_ready, leave FIFO state unchanged, and set overflow_error until reset.
REQ-021 SHALL give a pushed tag minimum latency 1 cycle: pushed at edge N, visible on enqueue_valid in cycle N+1 (unless REQ-029 applies).
REQ-022 SHALL preserve order: tags leave in push order.
REQ-023 SHALL wrap both pointers modulo DEPTH, toggling msb on wrap.
REQ-024 SHALL register count = next_tail - next_head (LOG_DEPTH+1 bits, modular).

Reset
REQ-025 SHALL on RST=1 at a rising edge clear head and tail to 0/msb 0, count=0, overflow_error=0, retire_ready=1.
REQ-026 SHALL drive enqueue_valid=0 in the cycle after reset and while RST is held. FIFO contents are don't-care.
REQ-027 SHALL discard entries in flight on reset mid-operation. No enqueue_valid follows reset until a new push.
REQ-028 SHALL let RST override all same-cycle retire/stall inputs.

Configuration
REQ-029 SHALL implement macro RECLAIM_BYPASS_EN:
- Defined: when FIFO empty, ~drain_stall, and a valid non-zero-arch retire is accepted, the block forwards the tag combinationally to enqueue_valid/enqueue_phys_reg_tag in the same cycle. Nothing is written; count stays 0.
- Undefined: latency is always REQ-021. All other behaviour is identical.

Verification
REQ-030 SHALL cover: reset, then retire (arch 5, phys 40) at cycle 1 -> enqueue_valid=1 tag 40 at cycle 2 (bypass off) or cycle 1 (bypass on); count returns 0.
REQ-031 SHALL cover: drain_stall=1, retire phys 33..40 (8 tags) -> count=8, retire_ready=0 from the cycle after the 8th push; 9th retire sets overflow_error=1 and count stays 8.
REQ-032 SHALL cover: release stall on full queue -> tags 33..40 emitted in order, one per cycle; retire_ready=1 the cycle after the first pop.
REQ-033 SHALL cover: retire with arch 0, phys 12 -> no push, count=0, no enqueue_valid.
REQ-034 SHALL cover: steady push+pop for 20 cycles, tags 48..67 -> count constant, pointers wrap twice, output order preserved.
REQ-035 SHALL cover: RST asserted with count=5 -> next cycle count=0, enqueue_valid=0, overflow_error=0, retire_ready=1.
